// File: rtl/aclk_pkg.sv
// Shared types and digit limits for the alarm-clock time path
// (current-time counter, alarm register, alarm comparator).
package aclk_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t ms_hr;
        bcd_t ls_hr;
        bcd_t ms_min;
        bcd_t ls_min;
    } time_t;

    localparam bcd_t MAX_MS_HR      = 4'd2;
    localparam bcd_t MAX_LS_HR_AT_2 = 4'd3;
    localparam bcd_t MAX_MS_MIN     = 4'd5;
    localparam bcd_t MAX_LS_MIN     = 4'd9;
    localparam bcd_t MAX_BCD_DIGIT  = 4'd9;

endpackage

// File: rtl/aclk_time_check.sv
// Combinational range check of a four-digit 24-hour BCD time.
module aclk_time_check
    import aclk_pkg::*;
(
    input  time_t t,
    output logic  valid
);

    logic hr_ok;

    always_comb begin
        hr_ok = 1'b0;
        if (t.ms_hr == MAX_MS_HR)
            hr_ok = (t.ls_hr <= MAX_LS_HR_AT_2);
        else if (t.ms_hr < MAX_MS_HR)
            hr_ok = (t.ls_hr <= MAX_BCD_DIGIT);
        valid = hr_ok && (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_LS_MIN);
    end

endmodule

// File: rtl/aclk_counter.sv
// Current-time counter: advances HH:MM on one_minute, accepts range-checked
// loads (load wins over the strobe, which is then dropped).
module aclk_counter
    import aclk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       load_new_c,
    input  logic [3:0] new_current_time_ms_hr,
    input  logic [3:0] new_current_time_ls_hr,
    input  logic [3:0] new_current_time_ms_min,
    input  logic [3:0] new_current_time_ls_min,
    output logic [3:0] current_time_ms_hr,
    output logic [3:0] current_time_ls_hr,
    output logic [3:0] current_time_ms_min,
    output logic [3:0] current_time_ls_min,
    output logic       rollover,
    output logic       load_err
);

    time_t cur;
    time_t new_time;
    time_t inc_time;
    logic  load_valid;
    logic  wrap;

    assign new_time = '{ms_hr:  new_current_time_ms_hr,
                        ls_hr:  new_current_time_ls_hr,
                        ms_min: new_current_time_ms_min,
                        ls_min: new_current_time_ls_min};

    aclk_time_check u_load_check (
        .t     (new_time),
        .valid (load_valid)
    );

    // BCD carry chain; 23:59 wraps to 00:00 and flags the wrap
    always_comb begin
        inc_time = cur;
        wrap     = 1'b0;
        if (cur.ls_min == MAX_LS_MIN) begin
            inc_time.ls_min = '0;
            if (cur.ms_min == MAX_MS_MIN) begin
                inc_time.ms_min = '0;
                if (cur.ms_hr == MAX_MS_HR && cur.ls_hr == MAX_LS_HR_AT_2) begin
                    inc_time.ms_hr = '0;
                    inc_time.ls_hr = '0;
                    wrap           = 1'b1;
                end else if (cur.ls_hr == MAX_BCD_DIGIT) begin
                    inc_time.ls_hr = '0;
                    inc_time.ms_hr = cur.ms_hr + 4'd1;
                end else begin
                    inc_time.ls_hr = cur.ls_hr + 4'd1;
                end
            end else begin
                inc_time.ms_min = cur.ms_min + 4'd1;
            end
        end else begin
            inc_time.ls_min = cur.ls_min + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur      <= '0;
            rollover <= 1'b0;
            load_err <= 1'b0;
        end else begin
            rollover <= 1'b0;
            load_err <= 1'b0;
            if (load_new_c) begin
                if (load_valid)
                    cur <= new_time;
                else
                    load_err <= 1'b1;
            end else if (one_minute) begin
                cur      <= inc_time;
                rollover <= wrap;
            end
        end
    end

    assign current_time_ms_hr  = cur.ms_hr;
    assign current_time_ls_hr  = cur.ls_hr;
    assign current_time_ms_min = cur.ms_min;
    assign current_time_ls_min = cur.ls_min;

endmodule

// File: tb/tb_aclk_counter.sv
// Self-checking bench for aclk_counter: minutes-of-day reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_aclk_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       one_minute = 1'b0;
    logic       load_new_c = 1'b0;
    logic [3:0] n_ms_hr = '0, n_ls_hr = '0, n_ms_min = '0, n_ls_min = '0;
    logic [3:0] c_ms_hr, c_ls_hr, c_ms_min, c_ls_min;
    logic       rollover, load_err;

    int checks = 0;
    int errors = 0;

    aclk_counter dut (
        .clk                     (clk),
        .reset                   (reset),
        .one_minute              (one_minute),
        .load_new_c              (load_new_c),
        .new_current_time_ms_hr  (n_ms_hr),
        .new_current_time_ls_hr  (n_ls_hr),
        .new_current_time_ms_min (n_ms_min),
        .new_current_time_ls_min (n_ls_min),
        .current_time_ms_hr      (c_ms_hr),
        .current_time_ls_hr      (c_ls_hr),
        .current_time_ms_min     (c_ms_min),
        .current_time_ls_min     (c_ls_min),
        .rollover                (rollover),
        .load_err                (load_err)
    );

    always #5 clk = ~clk;

    // Reference: time of day as minutes since midnight
    int   m_min = 0;
    logic m_roll = 1'b0;
    logic m_err = 1'b0;

    function automatic logic req_valid(input logic [15:0] t);
        int h, mm;
        h  = int'(t[15:12]) * 10 + int'(t[11:8]);
        mm = int'(t[7:4]) * 10 + int'(t[3:0]);
        return t[15:12] <= 2 && t[11:8] <= 9 && t[7:4] <= 5 && t[3:0] <= 9 && h < 24 && mm < 60;
    endfunction

    function automatic logic [15:0] to_hhmm(input int m);
        int h, mm;
        logic [15:0] r;
        h  = m / 60;
        mm = m % 60;
        r  = {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_min  = 0;
            m_roll = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_roll = 1'b0;
            m_err  = 1'b0;
            if (load_new_c) begin
                if (req_valid({n_ms_hr, n_ls_hr, n_ms_min, n_ls_min}))
                    m_min = (int'(n_ms_hr) * 10 + int'(n_ls_hr)) * 60
                          + int'(n_ms_min) * 10 + int'(n_ls_min);
                else
                    m_err = 1'b1;
            end else if (one_minute) begin
                m_roll = (m_min == 1439);
                m_min  = (m_min + 1) % 1440;
            end
        end
    end

    wire [15:0] dut_time = {c_ms_hr, c_ls_hr, c_ms_min, c_ls_min};

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (dut_time !== to_hhmm(m_min) || rollover !== m_roll || load_err !== m_err) begin
                errors++;
                $display("FAIL model_cmp t=%0t: got time %h roll %b err %b, want time %h roll %b err %b",
                         $time, dut_time, rollover, load_err, to_hhmm(m_min), m_roll, m_err);
            end
        end
    end

    task automatic check_lit(input string name, input logic [15:0] exp_t,
                             input logic exp_roll, input logic exp_err);
        checks++;
        if (dut_time !== exp_t || rollover !== exp_roll || load_err !== exp_err) begin
            errors++;
            $display("FAIL %s: got time %h roll %b err %b, want time %h roll %b err %b",
                     name, dut_time, rollover, load_err, exp_t, exp_roll, exp_err);
        end
    endtask

    // Called at posedge+2; applies inputs for one edge, returns at next posedge+2
    task automatic cycle(input logic om, input logic ld, input logic [15:0] t);
        one_minute = om;
        load_new_c = ld;
        {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = t;
        @(posedge clk);
        #2;
        one_minute = 1'b0;
        load_new_c = 1'b0;
    endtask

    initial begin
        logic [15:0] rt;
        repeat (2) @(posedge clk);
        #2;
        check_lit("reset_state", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;

        repeat (10) cycle(1'b1, 1'b0, '0);
        check_lit("ten_strobes", 16'h0010, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 16'h1259);
        check_lit("load_1259", 16'h1259, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0);
        check_lit("inc_1300", 16'h1300, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0959);
        cycle(1'b1, 1'b0, '0);
        check_lit("inc_1000", 16'h1000, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 16'h2359);
        cycle(1'b1, 1'b0, '0);
        check_lit("rollover_pulse", 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0);
        check_lit("rollover_clear", 16'h0000, 1'b0, 1'b0);

        cycle(1'b0, 1'b1, 16'h0000);
        check_lit("load_0000_no_roll", 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0741);
        cycle(1'b0, 1'b1, 16'h2400);
        check_lit("bad_2400", 16'h0741, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 16'h1960);
        check_lit("bad_1960", 16'h0741, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 16'h1A00);
        check_lit("bad_1A00", 16'h0741, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0);
        check_lit("err_clear", 16'h0741, 1'b0, 1'b0);

        cycle(1'b1, 1'b1, 16'h0830);
        check_lit("load_beats_strobe", 16'h0830, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'h2500);
        check_lit("bad_load_drops_strobe", 16'h0830, 1'b0, 1'b1);

        cycle(1'b0, 1'b1, 16'h1542);
        #1 reset = 1'b1;
        #1 check_lit("async_reset", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        cycle(1'b1, 1'b0, '0);
        check_lit("after_reset_inc", 16'h0001, 1'b0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(3))
                0: rt = 16'($urandom);
                1: rt = {4'h2, 4'h3, 4'h5, 4'($urandom_range(9))};
                default: rt = {4'($urandom_range(2)), 4'($urandom_range(9)),
                               4'($urandom_range(5)), 4'($urandom_range(9))};
            endcase
            cycle(1'($urandom_range(99) < 70), 1'($urandom_range(99) < 15), rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aclk_counter.md
# aclk_counter

Alarm-clock current-time counter, directly downstream of the time generator. Consumes the single-cycle `one_minute` strobe and advances a 24-hour BCD time (HH:MM). Supports synchronous loading of a user-entered time with range checking. Its outputs feed the display driver and the alarm comparator.

## Interface
- Parameters: none.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; forces time to 00:00.
- `one_minute`  in  1  one-cycle strobe from the time generator; advance time by one minute.
- `load_new_c`  in  1  one-cycle request to load `new_current_time_*`.
- `new_current_time_ms_hr`  in  4  BCD tens-of-hours to load.
- `new_current_time_ls_hr`  in  4  BCD units-of-hours to load.
- `new_current_time_ms_min`  in  4  BCD tens-of-minutes to load.
- `new_current_time_ls_min`  in  4  BCD units-of-minutes to load.
- `current_time_ms_hr`  out  4  registered BCD tens-of-hours.
- `current_time_ls_hr`  out  4  registered BCD units-of-hours.
- `current_time_ms_min`  out  4  registered BCD tens-of-minutes.
- `current_time_ls_min`  out  4  registered BCD units-of-minutes.
- `rollover`  out  1  one-cycle pulse when time wraps 23:59 -> 00:00.
- `load_err`  out  1  one-cycle pulse when a load request is rejected.

## Operation
- Reset values:
  - all `current_time_*` = 0;
  - `rollover` = 0;
  - `load_err` = 0.
- Per-cycle priority:
  1. `load_new_c`
  2. `one_minute`
  3. hold.
- Load validity (all four must hold):
  - ms_hr 0-2;
  - ls_hr 0-9, or 0-3 when ms_hr = 2;
  - ms_min 0-5;
  - ls_min 0-9.
- Valid load: all four digits are replaced on the next edge. `load_err` = 0.
- Invalid load: time is unchanged and `load_err` pulses for one cycle.
- A `one_minute` arriving in the same cycle as any load is discarded, whether the load is valid or not. It is never deferred.
- Increment carry chain:
  - ls_min 9 -> 0, carry into ms_min;
  - ms_min 5 -> 0, carry into hours;
  - hours increment ls_hr with 9 -> 0 and carry into ms_hr;
  - special case 23 -> 00.
- Arithmetic is pure BCD. Binary values 10-15 never appear on any output.
- `rollover` pulses only on an increment from 23:59. A load of 00:00 does not pulse it.
- `rollover` and `load_err` are mutually exclusive by construction.
- Fast-watch mode needs no special handling here. The generator raises `one_minute` more often; the counter behaves identically.

## Timing
- Latency: strobe or load sampled at edge N; new time visible on outputs after edge N.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `one_minute` on consecutive cycles increments once per cycle. There is no rate limit.
- Reset asserted mid-operation clears everything asynchronously, including a pending `rollover` or `load_err`.
- After reset deasserts, the first edge processes inputs normally.
- `load_new_c` held high for several cycles reloads (and rechecks) every cycle.

## Structure
- Shared package `aclk_pkg` holds:
  - a 4-bit BCD digit typedef;
  - a four-digit time struct (ms_hr, ls_hr, ms_min, ls_min);
  - digit limit constants (`MAX_MS_HR`=2, `MAX_LS_HR_AT_2`=3, `MAX_MS_MIN`=5, `MAX_LS_MIN`=9).
- Use the same package in the alarm register and comparator.
- One sub-module: `aclk_time_check`.
  - Purely combinational.
  - Takes a four-digit time and returns `valid`.
  - Reused later by the alarm-time register.
- The carry chain stays inline in `aclk_counter`.

## Test plan
- Reset release, then 10 `one_minute` strobes -> 00:10 with no `rollover`.
- Load 12:59 (valid), then one strobe -> 13:00. Then load 09:59, one strobe -> 10:00.
- Load 23:59, one strobe -> 00:00 and `rollover` high for exactly one cycle.
- Load 24:00, 19:60 and 1A:00 in turn -> each gives a one-cycle `load_err` pulse; time stays at its previous value.
- `load_new_c` (08:30) and `one_minute` in the same cycle -> result 08:30, not 08:31.
- Assert reset asynchronously between edges while at 15:42 -> outputs read 00:00 immediately; the next strobe after release gives 00:01.
